// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM for the RV64I datapath: owns the PC, fetches, decodes ld/sd/add/sub/addi
// and sequences every select and write enable. Define BEQ_EN to also accept beq.
module unidade_controle_multiciclo #(
    parameter int PC_W       = 5,
    parameter int PC_INICIAL = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instr,
    input  logic            zero,
    output logic [PC_W-1:0] endr,
    output logic [4:0]      Ra,
    output logic [4:0]      Rb,
    output logic [4:0]      Rw,
    output logic            we_reg,
    output logic            we_mem,
    output logic [63:0]     constante,
    output logic            soma_ou_subtrai,
    output logic            subtraindo,
    output logic [1:0]      escolhe_entrada1,
    output logic [1:0]      escolhe_entrada2,
    output logic            sel_din,
    output logic            parado
);

    typedef enum logic [2:0] {
        BUSCA = 3'd0,
        DECOD = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        HALT  = 3'd4
    } estado_t;

    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [1:0] SEL_A = 2'd1;
    localparam logic [1:0] SEL_B = 2'd0;
    localparam logic [1:0] SEL_C = 2'd2;

    localparam logic [PC_W-1:0] PC_UM = {{(PC_W-1){1'b0}}, 1'b1};

    estado_t         r_state;
    estado_t         w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_pc_target;
    logic [31:0]     r_ir;

    logic [31:0] w_word;
    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [63:0] w_imm_i;
    logic [63:0] w_imm_s;

    logic        w_legal;
    logic        w_is_ld;
    logic        w_is_sd;
    logic        w_is_alu;
    logic        w_is_beq;
    logic        w_sub;
    logic [1:0]  w_in1;
    logic [1:0]  w_in2;
    logic [63:0] w_imm;
    logic [4:0]  w_ra;
    logic [4:0]  w_rb;
    logic [4:0]  w_rw;
    logic        w_sel_din;
    logic        w_drive;

    // instr is only valid during DECOD; afterwards the latched IR keeps the selects stable.
    assign w_word  = (r_state == DECOD) ? instr : r_ir;
    assign w_op    = w_word[6:0];
    assign w_f3    = w_word[14:12];
    assign w_f7    = w_word[31:25];
    assign w_rd    = w_word[11:7];
    assign w_rs1   = w_word[19:15];
    assign w_rs2   = w_word[24:20];
    assign w_imm_i = {{52{w_word[31]}}, w_word[31:20]};
    assign w_imm_s = {{52{w_word[31]}}, w_word[31:25], w_word[11:7]};

    always_comb begin
        w_legal   = 1'b0;
        w_is_ld   = 1'b0;
        w_is_sd   = 1'b0;
        w_is_alu  = 1'b0;
        w_is_beq  = 1'b0;
        w_sub     = 1'b0;
        w_in1     = SEL_B;
        w_in2     = SEL_B;
        w_imm     = 64'd0;
        w_ra      = 5'd0;
        w_rb      = 5'd0;
        w_rw      = 5'd0;
        w_sel_din = 1'b0;
        case (w_op)
            OP_LD: if (w_f3 == 3'b011) begin
                w_legal = 1'b1;
                w_is_ld = 1'b1;
                w_rb    = w_rs1;
                w_in2   = SEL_C;
                w_imm   = w_imm_i;
                w_rw    = w_rd;
            end
            OP_SD: if (w_f3 == 3'b011) begin
                w_legal = 1'b1;
                w_is_sd = 1'b1;
                w_rb    = w_rs1;
                w_ra    = w_rs2;
                w_in2   = SEL_C;
                w_imm   = w_imm_s;
            end
            OP_R: if (w_f3 == 3'b000 && (w_f7 == 7'b0000000 || w_f7 == 7'b0100000)) begin
                w_legal   = 1'b1;
                w_is_alu  = 1'b1;
                w_ra      = w_rs1;
                w_rb      = w_rs2;
                w_in1     = SEL_A;
                w_sub     = w_f7[5];
                w_rw      = w_rd;
                w_sel_din = 1'b1;
            end
            OP_ADDI: if (w_f3 == 3'b000) begin
                w_legal   = 1'b1;
                w_is_alu  = 1'b1;
                w_rb      = w_rs1;
                w_in2     = SEL_C;
                w_imm     = w_imm_i;
                w_rw      = w_rd;
                w_sel_din = 1'b1;
            end
`ifdef BEQ_EN
            OP_BEQ: if (w_f3 == 3'b000) begin
                w_legal  = 1'b1;
                w_is_beq = 1'b1;
                w_ra     = w_rs1;
                w_rb     = w_rs2;
                w_in1    = SEL_A;
                w_sub    = 1'b1;
            end
`endif
            default: w_legal = 1'b0;
        endcase
    end

`ifdef BEQ_EN
    logic [63:0] w_imm_b;
    // B offset is taken literally as a word count, so its implicit zero LSB stays in.
    assign w_imm_b     = {{51{w_word[31]}}, w_word[31], w_word[7], w_word[30:25], w_word[11:8], 1'b0};
    assign w_pc_target = (w_is_beq && zero) ? (r_pc + w_imm_b[PC_W-1:0]) : (r_pc + PC_UM);
`else
    logic w_unused_zero;
    assign w_unused_zero = zero ^ (w_op == OP_BEQ);
    assign w_pc_target   = r_pc + PC_UM;
`endif

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_drive          = 1'b0;
        Ra               = 5'd0;
        Rb               = 5'd0;
        Rw               = 5'd0;
        we_reg           = 1'b0;
        we_mem           = 1'b0;
        constante        = 64'd0;
        soma_ou_subtrai  = 1'b0;
        subtraindo       = 1'b0;
        escolhe_entrada1 = 2'd0;
        escolhe_entrada2 = 2'd0;
        sel_din          = 1'b0;
        parado           = 1'b0;
        case (r_state)
            BUSCA: w_state_next = DECOD;
            DECOD: begin
                w_drive      = w_legal;
                w_state_next = w_legal ? EXEC : HALT;
            end
            EXEC: begin
                w_drive = 1'b1;
                if (w_is_ld) begin
                    w_state_next = MEM;
                end else begin
                    we_reg       = w_is_alu && (w_rd != 5'd0);
                    we_mem       = w_is_sd;
                    w_pc_next    = w_pc_target;
                    w_state_next = BUSCA;
                end
            end
            MEM: begin
                w_drive      = 1'b1;
                we_reg       = (w_rd != 5'd0);
                w_pc_next    = r_pc + PC_UM;
                w_state_next = BUSCA;
            end
            HALT: parado = 1'b1;
            default: w_state_next = BUSCA;
        endcase
        if (w_drive) begin
            Ra               = w_ra;
            Rb               = w_rb;
            Rw               = w_rw;
            constante        = w_imm;
            soma_ou_subtrai  = 1'b1;
            subtraindo       = w_sub;
            escolhe_entrada1 = w_in1;
            escolhe_entrada2 = w_in2;
            sel_din          = w_sel_din;
        end
    end

    assign endr = r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BUSCA;
            r_pc    <= PC_W'(PC_INICIAL);
            r_ir    <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (r_state == DECOD) begin
                r_ir <= instr;
            end
        end
    end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed bench for unidade_controle_multiciclo: a synchronous-read instruction memory model
// feeds hand-assembled programs and each step is checked with immediate assertions.
module tb_unidade_controle_multiciclo;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic [4:0]  endr;
    logic [4:0]  Ra, Rb, Rw;
    logic        we_reg, we_mem;
    logic [63:0] constante;
    logic        soma_ou_subtrai, subtraindo;
    logic [1:0]  escolhe_entrada1, escolhe_entrada2;
    logic        sel_din, parado;

    logic [31:0] imem [32];
    int total = 0;
    int bad   = 0;

    localparam logic [31:0] I_LD   = 32'h00803083;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h40208233;
    localparam logic [31:0] I_ADDI = 32'hFFD08293;
    localparam logic [31:0] I_SD   = 32'h02103423;
    localparam logic [31:0] I_NOP0 = 32'h00100013;
    localparam logic [31:0] I_BEQ  = 32'hFE108FE3;

    unidade_controle_multiciclo #(.PC_W(5), .PC_INICIAL(0)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .endr(endr),
        .Ra(Ra), .Rb(Rb), .Rw(Rw), .we_reg(we_reg), .we_mem(we_mem),
        .constante(constante), .soma_ou_subtrai(soma_ou_subtrai), .subtraindo(subtraindo),
        .escolhe_entrada1(escolhe_entrada1), .escolhe_entrada2(escolhe_entrada2),
        .sel_din(sel_din), .parado(parado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) instr <= imem[endr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill(input logic [31:0] w);
        for (int k = 0; k < 32; k++) imem[k] = w;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        zero  = 1'b0;
        fill(I_NOP0);
        imem[0] = I_LD;  imem[1] = I_ADD; imem[2] = I_SUB;
        imem[3] = I_ADDI; imem[4] = I_SD; imem[5] = I_ADD;
        #1 rst_n = 1'b0;
        #2;
        check("rst_endr", endr, 0);
        check("rst_we_reg", we_reg, 0);
        check("rst_we_mem", we_mem, 0);
        check("rst_soma", soma_ou_subtrai, 0);
        check("rst_const", constante, 0);
        check("rst_parado", parado, 0);
        tick(2);
        release_reset();

        // ld x1,8(x0)
        tick();
        check("ld_dec_rb", Rb, 0);
        check("ld_dec_const", constante, 8);
        check("ld_dec_in1", escolhe_entrada1, 0);
        check("ld_dec_in2", escolhe_entrada2, 2);
        check("ld_dec_soma", soma_ou_subtrai, 1);
        check("ld_dec_we", we_reg, 0);
        tick();
        check("ld_exec_we", we_reg, 0);
        tick();
        check("ld_mem_we", we_reg, 1);
        check("ld_mem_rw", Rw, 1);
        check("ld_mem_seldin", sel_din, 0);
        check("ld_mem_wemem", we_mem, 0);
        tick();
        check("ld_next_endr", endr, 1);
        check("ld_next_we", we_reg, 0);

        // add x3,x1,x2
        tick();
        check("add_dec_ra", Ra, 1);
        check("add_dec_rb", Rb, 2);
        check("add_dec_in1", escolhe_entrada1, 1);
        check("add_dec_in2", escolhe_entrada2, 0);
        check("add_dec_seldin", sel_din, 1);
        check("add_dec_sub", subtraindo, 0);
        check("add_dec_we", we_reg, 0);
        tick();
        check("add_exec_we", we_reg, 1);
        check("add_exec_rw", Rw, 3);
        tick();
        check("add_next_endr", endr, 2);
        check("add_next_we", we_reg, 0);

        // sub x4,x1,x2
        tick();
        check("sub_dec_sub", subtraindo, 1);
        tick();
        check("sub_exec_we", we_reg, 1);
        check("sub_exec_rw", Rw, 4);
        check("sub_exec_sub", subtraindo, 1);
        tick();
        check("sub_next_endr", endr, 3);

        // addi x5,x1,-3
        tick();
        check("addi_const", constante, 64'hFFFF_FFFF_FFFF_FFFD);
        check("addi_rb", Rb, 1);
        check("addi_in1", escolhe_entrada1, 0);
        check("addi_in2", escolhe_entrada2, 2);
        check("addi_rw", Rw, 5);
        tick();
        check("addi_exec_we", we_reg, 1);
        tick();
        check("addi_next_endr", endr, 4);

        // sd x1,40(x0)
        tick();
        check("sd_const", constante, 40);
        check("sd_rb", Rb, 0);
        check("sd_ra", Ra, 1);
        check("sd_dec_wemem", we_mem, 0);
        tick();
        check("sd_exec_wemem", we_mem, 1);
        check("sd_exec_wereg", we_reg, 0);
        tick();
        check("sd_next_wemem", we_mem, 0);
        check("sd_next_endr", endr, 5);

        // add at PC=5, reset pulse in the middle of EXEC
        tick(2);
        check("mid_exec_we", we_reg, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_we", we_reg, 0);
        check("async_rst_soma", soma_ou_subtrai, 0);
        check("async_rst_rw", Rw, 0);
        check("async_rst_endr", endr, 0);

        // illegal all-zero word at PC=3
        fill(I_NOP0);
        imem[3] = 32'h0000_0000;
        release_reset();
        tick();
        check("restart_dec_soma", soma_ou_subtrai, 1);
        check("restart_endr", endr, 0);
        tick();
        check("x0_exec_we", we_reg, 0);
        tick(7);
        check("ill_endr", endr, 3);
        tick();
        check("ill_dec_soma", soma_ou_subtrai, 0);
        tick();
        for (int k = 0; k < 20; k++) begin
            check("halt_parado", parado, 1);
            check("halt_we", {we_reg, we_mem, soma_ou_subtrai}, 0);
            check("halt_endr", endr, 3);
            tick();
        end

        // PC wrap with addi x0,x0,1
        rst_n = 1'b0;
        #1;
        check("halt_rst_parado", parado, 0);
        fill(I_NOP0);
        release_reset();
        tick(93);
        check("wrap_endr31", endr, 31);
        tick(2);
        check("wrap_exec_we", we_reg, 0);
        check("wrap_exec_soma", soma_ou_subtrai, 1);
        tick();
        check("wrap_endr0", endr, 0);

        rst_n = 1'b0;
        #1;
        fill(I_NOP0);
`ifdef BEQ_EN
        imem[6] = I_BEQ;
        release_reset();
        tick(18);
        check("beq_endr6", endr, 6);
        zero = 1'b1;
        tick();
        check("beq_dec_sub", subtraindo, 1);
        check("beq_dec_ra", Ra, 1);
        check("beq_dec_in1", escolhe_entrada1, 1);
        tick();
        check("beq_exec_we", {we_reg, we_mem}, 0);
        tick();
        check("beq_taken_endr", endr, 4);
        tick(6);
        check("beq_again_endr", endr, 6);
        zero = 1'b0;
        tick(3);
        check("beq_not_taken_endr", endr, 7);
`else
        imem[0] = I_BEQ;
        release_reset();
        zero = 1'b1;
        tick();
        check("beq_ill_soma", soma_ou_subtrai, 0);
        tick();
        check("beq_ill_parado", parado, 1);
        check("beq_ill_endr", endr, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
